onehot_encoder_seq: RTL and testbench



---
 rtl/onehot_encoder_seq.sv | 146 ++++++++++++++
 tb/tb_onehot_encoder_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/onehot_encoder_seq.sv
// onehot_encoder_seq: sequential inverse of the 3:8 one-hot decoder.
// Takes a request vector with any number of bits set and emits the binary
// index of each set bit, one per idx handshake beat.
//
// Build option:
//   ENC_MSB_FIRST_EN  defined   -> highest set bit is emitted first
//                     undefined -> lowest set bit is emitted first (default)
//
// idx, idx_valid and idx_last are decoded from registered state only, so
// req/req_valid never reach the outputs combinationally; idx_ready only
// steers the next-state logic.
module onehot_encoder_seq #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [N-1:0]  req,
    output logic          idx_valid,
    input  logic          idx_ready,
    output logic [IW-1:0] idx,
    output logic          idx_last,
    output logic          busy,
    output logic          zero_err
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  pend;
    logic [N-1:0]  pend_nxt;
    logic          zero_err_nxt;
    logic [IW-1:0] sel_idx;
    logic          sel_last;

    // Position of the lowest set bit; 0 when the vector is empty.
    function automatic logic [IW-1:0] lowest_set(input logic [N-1:0] v);
        logic [IW-1:0] pos;
        pos = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) begin
                pos = IW'(i);
            end
        end
        return pos;
    endfunction

    // Position of the highest set bit; 0 when the vector is empty.
    function automatic logic [IW-1:0] highest_set(input logic [N-1:0] v);
        logic [IW-1:0] pos;
        pos = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                pos = IW'(i);
            end
        end
        return pos;
    endfunction

    // True when exactly one bit of the vector is set.
    function automatic logic single_bit(input logic [N-1:0] v);
        return (v != '0) && ((v & (v - N'(1))) == '0);
    endfunction

    // One-hot mask selecting the given bit position.
    function automatic logic [N-1:0] bit_mask(input logic [IW-1:0] pos);
        logic [N-1:0] m;
        m = '0;
        m[pos] = 1'b1;
        return m;
    endfunction

    // Pick the bit to emit this beat according to the build-time order.
    always_comb begin
`ifdef ENC_MSB_FIRST_EN
        sel_idx  = highest_set(pend);
`else
        sel_idx  = lowest_set(pend);
`endif
        sel_last = single_bit(pend);
    end

    // Next-state, pending-bit update and output decode.
    always_comb begin
        state_nxt    = state;
        pend_nxt     = pend;
        zero_err_nxt = 1'b0;
        req_ready    = 1'b0;
        idx_valid    = 1'b0;
        idx          = '0;
        idx_last     = 1'b0;
        busy         = 1'b0;

        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req != '0) begin
                        pend_nxt  = req;
                        state_nxt = EMIT;
                    end else begin
                        // Empty vector: flag it, produce no beats.
                        zero_err_nxt = 1'b1;
                    end
                end
            end

            EMIT: begin
                busy      = 1'b1;
                idx_valid = 1'b1;
                idx       = sel_idx;
                idx_last  = sel_last;
                if (idx_ready) begin
                    pend_nxt = pend & ~bit_mask(sel_idx);
                    if (sel_last) begin
                        state_nxt = IDLE;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, pending vector and zero-vector pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            pend     <= '0;
            zero_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            pend     <= pend_nxt;
            zero_err <= zero_err_nxt;
        end
    end

endmodule

// File: tb/tb_onehot_encoder_seq.sv
// Directed bench for onehot_encoder_seq. Inputs change 1 ns after the rising
// edge; outputs are sampled at that same point, away from the edge.
// Honours ENC_MSB_FIRST_EN for the expected emission order.
module tb_onehot_encoder_seq;

    logic       clk;
    logic       reset_n;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req;
    logic       idx_valid;
    logic       idx_ready;
    logic [2:0] idx;
    logic       idx_last;
    logic       busy;
    logic       zero_err;

    int n_checks;
    int n_errors;

    onehot_encoder_seq #(.N(8), .IW(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req       (req),
        .idx_valid (idx_valid),
        .idx_ready (idx_ready),
        .idx       (idx),
        .idx_last  (idx_last),
        .busy      (busy),
        .zero_err  (zero_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".req_ready"}, {7'd0, req_ready}, 8'd1);
        check({tag, ".idx_valid"}, {7'd0, idx_valid}, 8'd0);
        check({tag, ".idx"},       {5'd0, idx},       8'd0);
        check({tag, ".idx_last"},  {7'd0, idx_last},  8'd0);
        check({tag, ".busy"},      {7'd0, busy},      8'd0);
    endtask

    task automatic check_beat(input string tag, input logic [2:0] e_idx, input logic e_last);
        check({tag, ".idx_valid"}, {7'd0, idx_valid}, 8'd1);
        check({tag, ".req_ready"}, {7'd0, req_ready}, 8'd0);
        check({tag, ".busy"},      {7'd0, busy},      8'd1);
        check({tag, ".idx"},       {5'd0, idx},       {5'd0, e_idx});
        check({tag, ".idx_last"},  {7'd0, idx_last},  {7'd0, e_last});
    endtask

    logic [2:0] multi_exp [3];
    logic [2:0] bp_first;
    logic [2:0] bp_second;
    logic [2:0] ff_exp [3];

    initial begin
        n_checks  = 0;
        n_errors  = 0;
`ifdef ENC_MSB_FIRST_EN
        multi_exp = '{3'd7, 3'd2, 3'd0};
        bp_first  = 3'd4;
        bp_second = 3'd3;
        ff_exp    = '{3'd7, 3'd6, 3'd5};
`else
        multi_exp = '{3'd0, 3'd2, 3'd7};
        bp_first  = 3'd3;
        bp_second = 3'd4;
        ff_exp    = '{3'd0, 3'd1, 3'd2};
`endif

        // Reset held, then released
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req       = 8'h00;
        idx_ready = 1'b0;
        tick();
        tick();
        check_idle("rst_hold");
        check("rst_hold.zero_err", {7'd0, zero_err}, 8'd0);
        reset_n = 1'b1;
        tick();
        check_idle("rst_rel");
        check("rst_rel.zero_err", {7'd0, zero_err}, 8'd0);

        // Single bit
        req       = 8'b0010_0000;
        req_valid = 1'b1;
        idx_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        req       = 8'h00;
        check_beat("single", 3'd5, 1'b1);
        tick();
        check_idle("single_done");

        // Multi-bit streaming
        req       = 8'b1000_0101;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        req       = 8'h00;
        for (int i = 0; i < 3; i++) begin
            check_beat($sformatf("multi%0d", i), multi_exp[i], (i == 2));
            tick();
        end
        check_idle("multi_done");

        // Backpressure, plus a req_valid pulse that must be ignored
        req       = 8'b0001_1000;
        req_valid = 1'b1;
        idx_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        req       = 8'h00;
        for (int i = 0; i < 4; i++) begin
            check_beat($sformatf("bp_hold%0d", i), bp_first, 1'b0);
            if (i == 1) begin
                req       = 8'hFF;
                req_valid = 1'b1;
            end else begin
                req       = 8'h00;
                req_valid = 1'b0;
            end
            tick();
        end
        idx_ready = 1'b1;
        check_beat("bp_go0", bp_first, 1'b0);
        tick();
        check_beat("bp_go1", bp_second, 1'b1);
        tick();
        check_idle("bp_done");

        // Zero vector
        req       = 8'h00;
        req_valid = 1'b1;
        check("zero_pre.zero_err", {7'd0, zero_err}, 8'd0);
        tick();
        req_valid = 1'b0;
        check("zero.zero_err", {7'd0, zero_err}, 8'd1);
        check_idle("zero");
        tick();
        check("zero_after.zero_err", {7'd0, zero_err}, 8'd0);
        check_idle("zero_after");

        // Reset mid-drain
        req       = 8'hFF;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        req       = 8'h00;
        for (int i = 0; i < 3; i++) begin
            check_beat($sformatf("ff%0d", i), ff_exp[i], 1'b0);
            tick();
        end
        check("ff_pre_rst.idx_valid", {7'd0, idx_valid}, 8'd1);
        reset_n = 1'b0;
        #1;
        check_idle("mid_rst");
        tick();
        reset_n = 1'b1;
        tick();
        check_idle("post_rst");
        req       = 8'b0100_0000;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        req       = 8'h00;
        check_beat("post_rst_beat", 3'd6, 1'b1);
        tick();
        check_idle("post_rst_done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
